// File: rtl/nonce_pkg.sv
// Shared types for the nonce scheduler: scheduler FSM states and the nonce word.
package nonce_pkg;

    typedef logic [31:0] nonce_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH,
        REPORT
    } state_t;

endpackage

// File: rtl/nonce_scheduler_if.sv
// Block/issue/result/found handshake bundle between the scheduler and its environment.
interface nonce_scheduler_if
    import nonce_pkg::*;
#(
    parameter int NUMPROCESSORS = 10
);
    logic                     block_valid_i;
    logic                     block_ready_o;
    logic                     abort_i;
    logic                     stall_i;
    logic                     issue_valid_o;
    nonce_t                   issue_base_o;
    logic                     result_valid_i;
    logic [NUMPROCESSORS-1:0] result_success_i;
    logic                     found_valid_o;
    nonce_t                   found_nonce_o;
    logic                     found_ready_i;
    logic                     exhausted_o;
    logic                     busy_o;

    modport master (
        output block_valid_i, abort_i, stall_i, result_valid_i, result_success_i, found_ready_i,
        input  block_ready_o, issue_valid_o, issue_base_o, found_valid_o, found_nonce_o,
               exhausted_o, busy_o
    );

    modport slave (
        input  block_valid_i, abort_i, stall_i, result_valid_i, result_success_i, found_ready_i,
        output block_ready_o, issue_valid_o, issue_base_o, found_valid_o, found_nonce_o,
               exhausted_o, busy_o
    );
endinterface

// File: rtl/base_fifo.sv
// Small first-word-fall-through FIFO holding the base nonce of every round still in flight.
module base_fifo
    import nonce_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  nonce_t wr_data,
    output nonce_t rd_data,
    output logic   full,
    output logic   empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    nonce_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            do_push;
    logic            do_pop;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/nonce_scheduler.sv
// Hands out rounds of consecutive nonces to parallel hash processors and reports the
// lowest winning nonce of the first successful round, or exhaustion of the nonce space.
module nonce_scheduler
    import nonce_pkg::*;
#(
    parameter int NUMPROCESSORS = 10,
    parameter int NONCESPACE    = 64,
    parameter int MAXINFLIGHT   = 4,
    parameter int PARTITIONBITS = $clog2(NUMPROCESSORS)
) (
    input logic              clk,
    input logic              rst,
    nonce_scheduler_if.slave bus
);
    localparam int IW = $clog2(MAXINFLIGHT + 1);

    state_t                   state_reg;
    logic [IW-1:0]            inflight_reg;
    nonce_t                   next_base_reg;
    logic                     found_reg;
    nonce_t                   found_nonce_reg;

    nonce_t                   head_base;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     issue_fire;
    logic                     pop;
    logic                     last_round;
    logic [NUMPROCESSORS-1:0] qual_mask;
    logic                     win_any;
    logic [PARTITIONBITS-1:0] win_idx;

    assign issue_fire = (state_reg == ISSUE) & ~bus.stall_i & ~bus.abort_i & ~fifo_full
                      & (inflight_reg < IW'(MAXINFLIGHT));
    assign pop        = bus.result_valid_i & ~fifo_empty;
    // Widened by one bit so a nonce space ending at 2^32 cannot wrap the compare.
    assign last_round = ({1'b0, next_base_reg} + 33'(NUMPROCESSORS)) >= 33'(NONCESPACE);

    base_fifo #(.DEPTH(MAXINFLIGHT)) u_base_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (issue_fire),
        .pop     (pop),
        .wr_data (next_base_reg),
        .rd_data (head_base),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUMPROCESSORS; gi++) begin : g_qual
            assign qual_mask[gi] = bus.result_success_i[gi]
                                 & (({1'b0, head_base} + 33'(gi)) < 33'(NONCESPACE));
        end
    endgenerate

    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        for (int i = NUMPROCESSORS - 1; i >= 0; i--) begin
            if (qual_mask[i]) begin
                win_any = 1'b1;
                win_idx = PARTITIONBITS'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            inflight_reg    <= '0;
            next_base_reg   <= '0;
            found_reg       <= 1'b0;
            found_nonce_reg <= '0;
        end else begin
            case ({issue_fire, pop})
                2'b10:   inflight_reg <= inflight_reg + IW'(1);
                2'b01:   inflight_reg <= inflight_reg - IW'(1);
                default: inflight_reg <= inflight_reg;
            endcase
            if (issue_fire) next_base_reg <= next_base_reg + nonce_t'(NUMPROCESSORS);

            case (state_reg)
                IDLE: begin
                    if (bus.block_valid_i) begin
                        next_base_reg <= '0;
                        found_reg     <= 1'b0;
                        state_reg     <= ISSUE;
                    end
                end
                ISSUE, DRAIN: begin
                    if (bus.abort_i) begin
                        found_reg <= 1'b0;
                        state_reg <= FLUSH;
                    end else if (pop && win_any) begin
                        found_reg       <= 1'b1;
                        found_nonce_reg <= head_base + nonce_t'(win_idx);
                        state_reg       <= FLUSH;
                    end else if (state_reg == ISSUE) begin
                        if (issue_fire && last_round) state_reg <= DRAIN;
                    end else if (pop && inflight_reg == IW'(1)) begin
                        state_reg <= IDLE;
                    end
                end
                FLUSH: begin
                    if (inflight_reg == '0) state_reg <= found_reg ? REPORT : IDLE;
                end
                REPORT: begin
                    if (bus.found_ready_i) begin
                        found_reg <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.block_ready_o = (state_reg == IDLE);
    assign bus.busy_o        = (state_reg != IDLE);
    assign bus.issue_valid_o = issue_fire;
    assign bus.issue_base_o  = next_base_reg;
    assign bus.found_valid_o = (state_reg == REPORT);
    assign bus.found_nonce_o = found_nonce_reg;
    assign bus.exhausted_o   = (state_reg == DRAIN) & pop & ~win_any & ~bus.abort_i
                             & (inflight_reg == IW'(1));
endmodule

// File: tb/tb_nonce_scheduler.sv
// Random and directed block searches checked against a queue-based model of round issue/results.
module tb_nonce_scheduler;
    import nonce_pkg::*;

    localparam int NP    = 10;
    localparam int NS    = 64;
    localparam int MAXIF = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nonce_scheduler_if #(.NUMPROCESSORS(NP)) bus ();

    nonce_scheduler #(
        .NUMPROCESSORS (NP),
        .NONCESPACE    (NS),
        .MAXINFLIGHT   (MAXIF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    // Model: outstanding round bases plus a few flags describing search progress.
    nonce_t mq[$];
    nonce_t m_nb;
    nonce_t m_win;
    bit     m_all, m_stop, m_haswin, m_rep, m_done;
    int     n_exh;
    nonce_t obs_found;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic st, input logic rv, input logic [NP-1:0] sc,
                         input logic ab, input logic bv, input logic fr);
        bus.stall_i          = st;
        bus.result_valid_i   = rv;
        bus.result_success_i = sc;
        bus.abort_i          = ab;
        bus.block_valid_i    = bv;
        bus.found_ready_i    = fr;
    endtask

    task automatic start_block();
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
        #1;
        check_eq("idle_ready", bus.block_ready_o, 1);
        check_eq("idle_busy", bus.busy_o, 0);
        check_eq("idle_found", bus.found_valid_o, 0);
        check_eq("idle_issue", bus.issue_valid_o, 0);
        mq.delete();
        m_nb = 0; m_all = 0; m_stop = 0; m_haswin = 0; m_rep = 0; m_done = 0;
        obs_found = '0;
    endtask

    task automatic step(input logic st, input logic rv, input logic [NP-1:0] sc,
                        input logic ab, input logic bv, input logic fr);
        bit     exp_issue, exp_exh, hit;
        nonce_t b;
        int     idx;
        @(posedge clk); #1;
        drive(st, rv, sc, ab, bv, fr);
        #1;
        exp_issue = !m_stop && !m_all && !st && !ab && (mq.size() < MAXIF);
        exp_exh   = 0;
        hit       = 0;
        idx       = 0;
        check_eq("busy", bus.busy_o, 1);
        check_eq("block_ready", bus.block_ready_o, 0);
        check_eq("issue_valid", bus.issue_valid_o, 32'(exp_issue));
        check_eq("issue_base", bus.issue_base_o, m_nb);
        check_eq("found_valid", bus.found_valid_o, 32'(m_rep));
        if (m_rep) begin
            check_eq("found_nonce", bus.found_nonce_o, m_win);
            obs_found = bus.found_nonce_o;
            if (fr) m_done = 1;
        end else if (m_stop) begin
            if (mq.size() == 0) begin
                if (m_haswin) m_rep = 1;
                else          m_done = 1;
            end else if (rv) begin
                void'(mq.pop_front());
            end
        end else begin
            if (rv && mq.size() != 0) begin
                b = mq.pop_front();
                for (int i = NP - 1; i >= 0; i--)
                    if (sc[i] && (longint'(b) + i < NS)) begin hit = 1; idx = i; end
                if (!ab && hit) begin
                    m_stop = 1; m_haswin = 1; m_win = b + nonce_t'(idx);
                end else if (!ab && m_all && mq.size() == 0) begin
                    exp_exh = 1; m_done = 1; n_exh++;
                end
            end
            if (ab) begin m_stop = 1; m_haswin = 0; end
            if (exp_issue) begin
                mq.push_back(m_nb);
                m_nb += NP;
                if (m_nb >= NS) m_all = 1;
            end
        end
        check_eq("exhausted", bus.exhausted_o, 32'(exp_exh));
    endtask

    task automatic end_block(input string name);
        check_eq({name, "_finished"}, 32'(m_done), 1);
        $display("block %s: found=%0d nonce=%0d exhausted_total=%0d", name, m_haswin, m_win, n_exh);
    endtask

    initial begin
        int             n, ex0;
        logic [NP-1:0]  sc;
        int             succ_pct, abort_pm;

        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        n_exh = 0;
        #2;
        check_eq("rst_ready", bus.block_ready_o, 1);
        check_eq("rst_busy", bus.busy_o, 0);
        check_eq("rst_issue_base", bus.issue_base_o, 0);
        check_eq("rst_found_nonce", bus.found_nonce_o, 0);
        #20 rst = 1'b1;

        // Full search with no success: bases 0..60, single exhaustion pulse.
        start_block();
        ex0 = n_exh;
        n = 0;
        while (!m_done && n < 200) begin step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0); n++; end
        check_eq("nosucc_exh_count", 32'(n_exh - ex0), 1);
        end_block("no_success");

        // Backpressure, stall, then winning round at base 20.
        start_block();
        repeat (5) step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 10'b0000100100, 1'b0, 1'b0, 1'b0);
        n = 0;
        while (!m_rep && n < 40) begin step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0); n++; end
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_eq("win20_nonce", bus.found_nonce_o, 22);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
        end_block("win_base20");

        // Partial last round: bit 5 at base 60 is out of range, bit 3 is not.
        for (int pass = 0; pass < 2; pass++) begin
            start_block();
            ex0 = n_exh;
            n = 0;
            while (!m_done && n < 200) begin
                sc = '0;
                if (mq.size() != 0 && mq[0] == 60) sc = (pass == 0) ? 10'b0000100000 : 10'b0000101000;
                step(1'b0, 1'b1, sc, 1'b0, 1'b0, 1'b1);
                n++;
            end
            if (pass == 0) check_eq("partial_masked_exh", 32'(n_exh - ex0), 1);
            else           check_eq("partial_nonce", obs_found, 63);
            end_block(pass == 0 ? "partial_masked" : "partial_win");
        end

        // Abort together with a winning result: nothing reported.
        start_block();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 10'b0000000001, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (!m_done && n < 40) begin step(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1); n++; end
        end_block("abort_vs_win");

        // Randomized blocks.
        for (int k = 0; k < 24; k++) begin
            succ_pct = (k % 3) * 20;
            abort_pm = (k % 4 == 3) ? 40 : 0;
            start_block();
            n = 0;
            while (!m_done && n < 400) begin
                sc = '0;
                if ($urandom_range(99) < succ_pct) begin
                    if ($urandom_range(1) == 1) sc[$urandom_range(NP - 1)] = 1'b1;
                    else                        sc = NP'($urandom);
                end
                step($urandom_range(99) < 25, $urandom_range(99) < 45, sc,
                     $urandom_range(999) < abort_pm, $urandom_range(1) == 1,
                     $urandom_range(99) < 40);
                n++;
            end
            end_block("random");
        end

        // Reset asserted mid-ISSUE, then a stray result after release.
        start_block();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check_eq("midrst_ready", bus.block_ready_o, 1);
        check_eq("midrst_issue", bus.issue_valid_o, 0);
        check_eq("midrst_busy", bus.busy_o, 0);
        check_eq("midrst_found", bus.found_valid_o, 0);
        check_eq("midrst_exh", bus.exhausted_o, 0);
        check_eq("midrst_base", bus.issue_base_o, 0);
        check_eq("midrst_nonce", bus.found_nonce_o, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b0, 1'b1, 10'b0000000001, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
        check_eq("stray_busy", bus.busy_o, 0);
        check_eq("stray_ready", bus.block_ready_o, 1);
        check_eq("stray_found", bus.found_valid_o, 0);
        check_eq("stray_exh", bus.exhausted_o, 0);
        $display("block reset_mid_issue: stray result after release ignored");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/nonce_scheduler.md
NONCE_SCHEDULER -- requirements
Module: nonce_scheduler

Interface
REQ-001 Parameter NUMPROCESSORS, default 10, number of parallel hash processors; each covers one nonce per round.
REQ-002 Parameter NONCESPACE, default 64, total nonces per block, covering nonces 0..NONCESPACE-1.
REQ-003 Parameter MAXINFLIGHT, default 4, maximum rounds issued but not yet answered.
REQ-004 Parameter PARTITIONBITS, default $clog2(NUMPROCESSORS), width of a processor index.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset; asynchronous and active-low: 0 resets, 1 runs.
REQ-007 block_valid_i  in  1  new block header is available; accepted when block_ready_o=1.
REQ-008 block_ready_o  out  1  scheduler is idle and accepts a block.
REQ-009 abort_i  in  1  abandon the current block.
REQ-010 stall_i  in  1  processors cannot accept a round this cycle.
REQ-011 issue_valid_o  out  1  a round is issued this cycle.
REQ-012 issue_base_o  out  32  first nonce of the issued round; processor i hashes issue_base_o+i.
REQ-013 result_valid_i  in  1  results for the oldest outstanding round; rounds complete in order.
REQ-014 result_success_i  in  NUMPROCESSORS  per-processor success flags for that round.
REQ-015 found_valid_o  out  1  winning nonce is available.
REQ-016 found_nonce_o  out  32  the winning nonce.
REQ-017 found_ready_i  in  1  consumer accepts the found nonce.
REQ-018 exhausted_o  out  1  one-cycle pulse: nonce space searched with no success.
REQ-019 busy_o  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, DRAIN, FLUSH, REPORT.
REQ-021 IDLE: block_ready_o=1; on block_valid_i, next_base:=0 and next state is ISSUE.
REQ-022 ISSUE: issue_valid_o = ~stall_i & (inflight<MAXINFLIGHT) & ~abort_i; on issue, push next_base into the base FIFO, inflight+1, next_base += NUMPROCESSORS.
REQ-023 Issue comparison SHALL be 33-bit: if next_base+NUMPROCESSORS >= NONCESPACE at issue, that round is the last one and the next state is DRAIN.
REQ-024 result_valid_i: pop the base FIFO and decrement inflight; an issue and a result in the same cycle leave inflight unchanged.
REQ-025 Bit i of result_success_i is qualified only if base+i < NONCESPACE (33-bit compare); unqualified bits are ignored.
REQ-026 Winner SHALL be the lowest qualified set index. found_nonce := base+index. found flag set. Next state is FLUSH.
REQ-027 Only the first winner per block counts; results in FLUSH are popped and discarded.
REQ-028 DRAIN: no issues. When the final result pops with no winner, exhausted_o pulses for exactly that cycle and the next state is IDLE.
REQ-029 FLUSH: no issues; when inflight==0 go to REPORT if found, else IDLE.
REQ-030 REPORT: found_valid_o=1 and found_nonce_o stable until found_ready_i. Found flag clears on that handshake; then go to IDLE.
REQ-031 abort_i in ISSUE or DRAIN goes to FLUSH with found cleared. If abort and a winning result arrive in the same cycle, abort wins and no found is reported.
REQ-032 abort_i in IDLE, FLUSH or REPORT SHALL be ignored.
REQ-033 result_valid_i with inflight==0 SHALL be ignored and SHALL NOT change state.
REQ-034 block_valid_i outside IDLE SHALL be ignored (block_ready_o=0).

Reset
REQ-035 On rst=0, asynchronously: state=IDLE; inflight=0; next_base=0; FIFO empty; found flag=0.
REQ-036 Output values under reset: block_ready_o=1; issue_valid_o, found_valid_o, exhausted_o and busy_o =0; issue_base_o and found_nonce_o =0.
REQ-037 Reset in any state, including mid-ISSUE, discards all in-flight bookkeeping; results after release are ignored per REQ-033.

Structure
REQ-038 Package nonce_pkg SHALL hold the FSM state enum and a 32-bit nonce_t typedef.
REQ-039 Base-nonce storage SHALL be a sub-module base_fifo: 32-bit width, depth MAXINFLIGHT, async active-low reset, push/pop/full/empty.
REQ-040 Winner selection SHALL be a combinational lowest-index priority encoder of width PARTITIONBITS, written inside nonce_scheduler.

Verification (NUMPROCESSORS=10, NONCESPACE=64, MAXINFLIGHT=4)
REQ-041 Search with no success: 7 rounds issued with bases 0,10,20,30,40,50,60; exhausted_o pulses once on the 7th result; found_valid_o never rises.
REQ-042 Winning round: result for base 20 with success=10'b0000100100 -> found_nonce_o=22; remaining in-flight results are flushed; REPORT holds until found_ready_i.
REQ-043 Partial last round: base 60 with success bit 5 only -> masked, exhausted_o pulses; base 60 with bits 5 and 3 -> found_nonce_o=63.
REQ-044 Backpressure: 4 issues with no results -> issue_valid_o=0 until a result returns; stall_i=1 -> no issue and issue_base_o unchanged.
REQ-045 Abort in ISSUE in the same cycle as a winning result -> FLUSH, no found_valid_o, IDLE once inflight==0.
REQ-046 rst=0 asserted mid-ISSUE -> outputs take their reset values immediately; after release, a stray result_valid_i is ignored.
